vector_modul: RTL and testbench

//  Sequential Euclidean-norm engine: Q_mod = isqrt(sum of A[k]^2, k=0..N-1) over N unsigned components.

---
 rtl/modul_pkg.sv | 33 +++
 rtl/isqrt_seq.sv | 81 ++++++++
 rtl/vector_modul.sv | 159 +++++++++++++++
 tb/tb_vector_modul.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/modul_pkg.sv
// Shared definitions for the vector_modul Euclidean-norm engine:
// FSM state encoding and the width helpers that size the accumulator
// and the square-root result from the component width and count.
package modul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SQRT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator width: a sum of n squares of w-bit values cannot overflow it.
  function automatic int s_width(input int w, input int n);
    return 2 * w + clog2(n);
  endfunction

  // Root width: half the accumulator width, rounded up.
  function automatic int r_width(input int w, input int n);
    return (s_width(w, n) + 1) / 2;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial restoring integer square root.
// A start pulse loads the radicand; R cycles later root = floor(sqrt(rad))
// and rem = rad - root^2. done is high during the last iteration cycle,
// so root/rem are final from the following cycle on.
module isqrt_seq
  import modul_pkg::*;
#(
  parameter int S = 29,
  parameter int R = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] rad,
  output logic         done,
  output logic [R-1:0] root,
  output logic [R:0]   rem
);

  localparam int CW = clog2(R) + 1;

  logic [2*R-1:0] rad_q;
  logic [R-1:0]   root_q;
  logic [R:0]     rem_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q;

  logic [2*R-1:0] rad_ext_s;
  logic [R+2:0]   trial_s;
  logic [R+2:0]   test_s;
  logic [R+2:0]   diff_s;
  logic           ge_s;
  logic [R:0]     root_sh_s;
  logic [R:0]     rem_nx_s;

  // Radicand is padded to an even bit count so it splits into whole pairs.
  assign rad_ext_s = (2 * R)'(rad);

  // Trial subtraction for one radicand pair: (rem<<2 | pair) - (root<<2 | 1).
  assign trial_s   = {rem_q, rad_q[2*R-1 -: 2]};
  assign test_s    = {1'b0, root_q, 2'b01};
  assign ge_s      = (trial_s >= test_s);
  assign diff_s    = ge_s ? (trial_s - test_s) : trial_s;
  // The partial remainder never exceeds 2*root, so R+1 bits always hold it.
  assign rem_nx_s  = diff_s[R:0];
  assign root_sh_s = {root_q, ge_s};

  assign done = run_q && (cnt_q == CW'(R - 1));
  assign root = root_q;
  assign rem  = rem_q;

  // Load on start, then one radicand pair per cycle, MSB pair first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      rad_q  <= rad_ext_s;
      root_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      rad_q  <= rad_q << 2;
      root_q <= root_sh_s[R-1:0];
      rem_q  <= rem_nx_s;
      cnt_q  <= cnt_q + CW'(1);
      if (done) begin
        run_q <= 1'b0;
      end else begin
        run_q <= 1'b1;
      end
    end else begin
      run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vector_modul.sv
// Sequential Euclidean-norm engine: Q_mod = isqrt(sum A[k]^2).
// One shared multiplier squares a snapshotted component per cycle into the
// accumulator, then isqrt_seq extracts the root bit-serially.
// Optional macro MODUL_ROUND_EN: round the root to nearest (saturating)
// instead of truncating.
module vector_modul
  import modul_pkg::*;
#(
  parameter int W = 14,
  parameter int N = 2,
  localparam int S = s_width(W, N),
  localparam int R = (S + 1) / 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           st,
  input  logic [N*W-1:0] A,
  output logic           busy,
  output logic           ok,
  output logic [R-1:0]   Q_mod
);

  localparam int IW = (N > 1) ? clog2(N) : 1;

  state_e         state_q;
  logic [W-1:0]   snap_q [N];
  logic [S-1:0]   acc_q;
  logic [IW-1:0]  idx_q;
  logic           busy_q;
  logic           ok_q;
  logic [R-1:0]   q_q;

  logic [W-1:0]   sel_s;
  logic [2*W-1:0] op_s;
  logic [2*W-1:0] prod_s;
  logic [S-1:0]   acc_nx_s;
  logic           last_s;
  logic           sq_start_s;
  logic           sq_done_s;
  logic [R-1:0]   sq_root_s;
  logic [R:0]     sq_rem_s;
  logic [R-1:0]   fin_s;

  // Select the component addressed by the running index.
  always_comb begin
    sel_s = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        sel_s = snap_q[k];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  assign op_s       = (2 * W)'(sel_s);
  assign prod_s     = op_s * op_s;
  assign acc_nx_s   = acc_q + S'(prod_s);
  assign last_s     = (idx_q == IW'(N - 1));
  // The root engine loads the sum including the final product.
  assign sq_start_s = (state_q == ST_ACC) && last_s;

  isqrt_seq #(
    .S(S),
    .R(R)
  ) u_isqrt (
    .clk  (clk),
    .rst_n(rst_n),
    .start(sq_start_s),
    .rad  (acc_nx_s),
    .done (sq_done_s),
    .root (sq_root_s),
    .rem  (sq_rem_s)
  );

`ifdef MODUL_ROUND_EN
  logic [R:0] inc_s;
  assign inc_s = {1'b0, sq_root_s} + (R + 1)'(1);

  // Round up when rem > root, i.e. sqrt(x) > root + 0.5; saturate at all ones.
  always_comb begin
    fin_s = sq_root_s;
    if (sq_rem_s > {1'b0, sq_root_s}) begin
      if (inc_s[R]) begin
        fin_s = '1;
      end else begin
        fin_s = inc_s[R-1:0];
      end
    end else begin
      fin_s = sq_root_s;
    end
  end
`else
  assign fin_s = sq_root_s;
`endif

  // Control FSM with snapshot, multiply-accumulate and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < N; k++) begin
        snap_q[k] <= '0;
      end
      acc_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      ok_q   <= 1'b0;
      q_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ok_q <= 1'b0;
          if (st) begin
            for (int k = 0; k < N; k++) begin
              snap_q[k] <= A[k*W +: W];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ACC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACC: begin
          acc_q <= acc_nx_s;
          if (last_s) begin
            state_q <= ST_SQRT;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_SQRT: begin
          if (sq_done_s) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SQRT;
          end
        end
        ST_DONE: begin
          q_q     <= fin_s;
          ok_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ok_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign ok    = ok_q;
  assign Q_mod = q_q;

endmodule

// File: tb/tb_vector_modul.sv
// Scoreboard bench for vector_modul: a W=14/N=2 instance and a W=8/N=4 instance.
// Drivers push expected results (and, where tagged, the expected ok cycle);
// per-instance monitors pop and compare whenever ok is seen.
module tb_vector_modul;

  localparam int W1 = 14, N1 = 2, R1 = 15;
  localparam int W2 = 8,  N2 = 4, R2 = 9;
  localparam int D1 = N1 + R1 + 2;   // drive negedge -> ok negedge
  localparam int D2 = N2 + R2 + 2;
`ifdef MODUL_ROUND_EN
  localparam int EXP23 = 4;
`else
  localparam int EXP23 = 3;
`endif

  typedef struct {
    int val;
    int cyc;
    bit lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st1 = 1'b0, st2 = 1'b0;
  logic [N1*W1-1:0] a1 = '0;
  logic [N2*W2-1:0] a2 = '0;
  logic busy1, ok1, busy2, ok2;
  logic [R1-1:0] q1;
  logic [R2-1:0] q2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  exp_t sb1[$];
  exp_t sb2[$];

  vector_modul #(.W(W1), .N(N1)) dut1 (
    .clk(clk), .rst_n(rst_n), .st(st1), .A(a1),
    .busy(busy1), .ok(ok1), .Q_mod(q1)
  );

  vector_modul #(.W(W2), .N(N2)) dut2 (
    .clk(clk), .rst_n(rst_n), .st(st2), .A(a2),
    .busy(busy2), .ok(ok2), .Q_mod(q2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor for the N=2 instance.
  always @(negedge clk) begin
    if (rst_n && ok1) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_ok: got Q_mod=%0d with no pending start", q1);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        check("dut1_q_mod", int'(q1), e.val);
        if (e.lat) check("dut1_ok_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for the N=4 instance.
  always @(negedge clk) begin
    if (rst_n && ok2) begin
      if (sb2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2_unexpected_ok: got Q_mod=%0d with no pending start", q2);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        check("dut2_q_mod", int'(q2), e.val);
        if (e.lat) check("dut2_ok_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb1.size() != 0 || sb2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb1.size() + sb2.size());
      sb1.delete();
      sb2.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run1(input int x0, input int x1, input int exp_v, input bit lat);
    @(negedge clk);
    a1  = {W1'(x1), W1'(x0)};
    st1 = 1'b1;
    sb1.push_back('{exp_v, cyc + D1, lat});
    @(negedge clk);
    st1 = 1'b0;
    drain("run1");
  endtask

  task automatic run2(input int x0, input int x1, input int x2, input int x3,
                      input int exp_v, input bit lat);
    @(negedge clk);
    a2  = {W2'(x3), W2'(x2), W2'(x1), W2'(x0)};
    st2 = 1'b1;
    sb2.push_back('{exp_v, cyc + D2, lat});
    @(negedge clk);
    st2 = 1'b0;
    drain("run2");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_q_mod", int'(q1), 0);
    check("reset_ok", int'(ok1), 0);
    check("reset_busy", int'(busy1), 0);
    check("reset_q_mod2", int'(q2), 0);
    // Idle period: any ok here is reported by the monitor.
    repeat (25) @(negedge clk);

    run1(3, 4, 5, 1'b1);
    run1(2, 3, EXP23, 1'b0);
    run1(0, 0, 0, 1'b0);
    run1(16383, 16383, 23169, 1'b1);

    // st held high: immediate re-trigger gives one result per N+R+2 cycles.
    @(negedge clk);
    a1  = {W1'(4), W1'(3)};
    st1 = 1'b1;
    sb1.push_back('{5, cyc + D1, 1'b1});
    sb1.push_back('{5, cyc + 2 * D1, 1'b1});
    repeat (D1 + 1) @(negedge clk);
    st1 = 1'b0;
    drain("held_st");

    // Mid-run st pulses and A changes are ignored.
    @(negedge clk);
    a1  = {W1'(12), W1'(5)};
    st1 = 1'b1;
    sb1.push_back('{13, cyc + D1, 1'b1});
    @(negedge clk);
    st1 = 1'b0;
    a1  = {W1'(1), W1'(1)};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      st1 = ~st1;
      a1  = a1 + (N1*W1)'(i);
    end
    st1 = 1'b0;
    check("busy_mid_run", int'(busy1), 1);
    drain("mid_run");

    // Abort in SQRT: outputs clear at once and no ok follows.
    @(negedge clk);
    a1  = {W1'(4), W1'(3)};
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_abort_busy", int'(busy1), 1);
    rst_n = 1'b0;
    #1;
    check("abort_q_mod", int'(q1), 0);
    check("abort_ok", int'(ok1), 0);
    check("abort_busy", int'(busy1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run1(6, 8, 10, 1'b1);

    run2(255, 255, 255, 255, 510, 1'b1);
    run2(1, 1, 1, 1, 2, 1'b0);
    run2(1, 2, 3, 4, 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
